// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multi-cycle RISC-V controller: FSM states, opcode
// constants, datapath select encodings and the per-state output decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALUWB     = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13,
    S_UPPER     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    CLS_LOAD    = 4'd0,
    CLS_STORE   = 4'd1,
    CLS_R       = 4'd2,
    CLS_I       = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       trap;
  } ctrl_out_t;

  // The mem_ready-qualified FETCH strobes are added outside; this is the pure Moore part.
  function automatic ctrl_out_t ctrl_outputs(input state_t s, input logic is_lui);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_read   = 1'b1;
        o.alu_src_a  = SRCA_PC;
        o.alu_src_b  = SRCB_FOUR;
        o.alu_op     = ALUOP_ADD;
        o.result_src = RES_ALU;
      end
      S_DECODE: begin
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        o.adr_src  = 1'b1;
        o.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o.result_src = RES_RDATA;
        o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o.adr_src   = 1'b1;
        o.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_RS2;
        o.alu_op    = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALUOP_ITYPE;
      end
      S_ALUWB: begin
        o.result_src = RES_ALUOUT;
        o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        o.alu_src_a  = SRCA_RS1;
        o.alu_src_b  = SRCB_RS2;
        o.alu_op     = ALUOP_SUB;
        o.result_src = RES_ALUOUT;
        o.branch     = 1'b1;
      end
      S_JAL: begin
        o.alu_src_a  = SRCA_OLDPC;
        o.alu_src_b  = SRCB_FOUR;
        o.alu_op     = ALUOP_ADD;
        o.result_src = RES_ALUOUT;
        o.pc_write   = 1'b1;
      end
      S_JALR: begin
        o.alu_src_a  = SRCA_RS1;
        o.alu_src_b  = SRCB_IMM;
        o.alu_op     = ALUOP_ADD;
        o.result_src = RES_ALU;
        o.pc_write   = 1'b1;
      end
      S_JALR_LINK: begin
        o.alu_src_a  = SRCA_OLDPC;
        o.alu_src_b  = SRCB_FOUR;
        o.alu_op     = ALUOP_ADD;
        o.result_src = RES_ALU;
        o.reg_write  = 1'b1;
      end
      S_UPPER: begin
        o.alu_src_a = is_lui ? SRCA_ZERO : SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALUOP_ADD;
      end
      S_TRAP: begin
        o.trap = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. The controller takes the master side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             branch;
  logic             ir_write;
  logic             adr_src;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       result_src;
  logic             trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, mem_ready,
    output pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, trap, instret
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, trap, instret
  );
endinterface

// File: rtl/multicycle_controller_classifier.sv
// Opcode to instruction-class decode; LUI/AUIPC become illegal when upper support is off.
module instr_classifier
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_UPPER = 1
) (
  input  logic [6:0]   i_opcode,
  output instr_class_t o_class,
  output logic         o_legal
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_LOAD:   o_class = CLS_LOAD;
      OP_STORE:  o_class = CLS_STORE;
      OP_R:      o_class = CLS_R;
      OP_I:      o_class = CLS_I;
      OP_BRANCH: o_class = CLS_BRANCH;
      OP_JAL:    o_class = CLS_JAL;
      OP_JALR:   o_class = CLS_JALR;
      OP_LUI:    o_class = (SUPPORT_UPPER != 0) ? CLS_LUI : CLS_ILLEGAL;
      OP_AUIPC:  o_class = (SUPPORT_UPPER != 0) ? CLS_AUIPC : CLS_ILLEGAL;
      default:   o_class = CLS_ILLEGAL;
    endcase
  end

  assign o_legal = (o_class != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM with registered Moore outputs, sticky trap
// and retired-instruction counter.
//
// state       | meaning
// RST         | post-reset idle, all outputs low
// FETCH       | instruction read, PC+4; IR/PC latch when memory ready
// DECODE      | branch/JAL target into ALUOut, dispatch on opcode
// MEMADR      | load/store address calculation
// MEMREAD     | data read, waits on mem_ready
// MEMWB       | load data to register file
// MEMWRITE    | data write, waits on mem_ready
// EXEC_R      | register-register ALU op
// EXEC_I      | register-immediate ALU op
// ALUWB       | ALUOut to register file
// BRANCH      | compare, conditional PC update
// JAL         | PC <- target, ALUOut <- oldPC+4
// JALR        | PC <- rs1+imm
// JALR_LINK   | rd <- oldPC+4
// UPPER       | LUI (0+imm) / AUIPC (oldPC+imm)
// TRAP        | illegal opcode, held until reset
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT      = 1,
  parameter int SUPPORT_UPPER = 1,
  parameter int CNT_W         = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_controller_if.master ctrl
);

  state_t           r_state;
  ctrl_out_t        r_out;
  logic [CNT_W-1:0] r_instret;

  state_t           w_next;
  instr_class_t     w_class;
  logic             w_legal;
  logic             w_ready;
  logic             w_fetch_go;

  instr_classifier #(
    .SUPPORT_UPPER(SUPPORT_UPPER)
  ) u_classifier (
    .i_opcode(ctrl.opcode),
    .o_class (w_class),
    .o_legal (w_legal)
  );

  assign w_ready = (MEM_WAIT != 0) ? ctrl.mem_ready : 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:       w_next = S_FETCH;
      S_FETCH:     w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_TRAP;
        end else begin
          case (w_class)
            CLS_LOAD, CLS_STORE: w_next = S_MEMADR;
            CLS_R:               w_next = S_EXEC_R;
            CLS_I:               w_next = S_EXEC_I;
            CLS_BRANCH:          w_next = S_BRANCH;
            CLS_JAL:             w_next = S_JAL;
            CLS_JALR:            w_next = S_JALR;
            CLS_LUI, CLS_AUIPC:  w_next = S_UPPER;
            default:             w_next = S_TRAP;
          endcase
        end
      end
      S_MEMADR:    w_next = (w_class == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:     w_next = S_FETCH;
      S_MEMWRITE:  w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:    w_next = S_ALUWB;
      S_EXEC_I:    w_next = S_ALUWB;
      S_ALUWB:     w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JAL:       w_next = S_ALUWB;
      S_JALR:      w_next = S_JALR_LINK;
      S_JALR_LINK: w_next = S_FETCH;
      S_UPPER:     w_next = S_ALUWB;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_RST;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still Moore-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_out     <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= ctrl_outputs(w_next, w_class == CLS_LUI);
      if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_RST) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign w_fetch_go = (r_state == S_FETCH) && w_ready;

  assign ctrl.pc_write   = r_out.pc_write | w_fetch_go;
  assign ctrl.ir_write   = r_out.ir_write | w_fetch_go;
  assign ctrl.branch     = r_out.branch;
  assign ctrl.adr_src    = r_out.adr_src;
  assign ctrl.mem_read   = r_out.mem_read;
  assign ctrl.mem_write  = r_out.mem_write;
  assign ctrl.reg_write  = r_out.reg_write;
  assign ctrl.alu_src_a  = r_out.alu_src_a;
  assign ctrl.alu_src_b  = r_out.alu_src_b;
  assign ctrl.alu_op     = r_out.alu_op;
  assign ctrl.result_src = r_out.result_src;
  assign ctrl.trap       = r_out.trap;
  assign ctrl.instret    = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: per-instruction expected cycle traces built from the
// instruction-level rules, replayed against two differently parameterised DUTs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic [6:0] tb_opc;
  logic       tb_rdy;
  int         sel;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) if1 ();
  multicycle_controller_if #(.CNT_W(4))  if2 ();

  assign if1.opcode    = tb_opc;
  assign if1.mem_ready = tb_rdy;
  assign if2.opcode    = tb_opc;
  assign if2.mem_ready = tb_rdy;

  multicycle_controller #(.MEM_WAIT(1), .SUPPORT_UPPER(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst1), .ctrl(if1.master));
  multicycle_controller #(.MEM_WAIT(0), .SUPPORT_UPPER(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst2), .ctrl(if2.master));

  wire [15:0] w_got1 = {if1.trap, if1.pc_write, if1.branch, if1.ir_write, if1.adr_src,
                        if1.mem_read, if1.mem_write, if1.reg_write, if1.alu_src_a,
                        if1.alu_src_b, if1.alu_op, if1.result_src};
  wire [15:0] w_got2 = {if2.trap, if2.pc_write, if2.branch, if2.ir_write, if2.adr_src,
                        if2.mem_read, if2.mem_write, if2.reg_write, if2.alu_src_a,
                        if2.alu_src_b, if2.alu_op, if2.result_src};

  typedef struct {
    logic        rdy;
    logic [6:0]  opc;
    logic [15:0] exp;
    int unsigned cnt;
  } rec_t;

  rec_t        q[$];
  logic [6:0]  cur_opc;
  int unsigned cur_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ov(input int t, input int pcw, input int br, input int irw,
                                     input int adr, input int mr, input int mw, input int rw,
                                     input int a, input int b, input int op, input int rs);
    return {t[0], pcw[0], br[0], irw[0], adr[0], mr[0], mw[0], rw[0],
            a[1:0], b[1:0], op[1:0], rs[1:0]};
  endfunction

  function automatic logic [6:0] kop(input int k);
    case (k)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      6: return 7'b1100111;
      7: return 7'b0110111;
      8: return 7'b0010111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic [15:0] e);
    rec_t x;
    x.rdy = r; x.opc = cur_opc; x.exp = e; x.cnt = cur_cnt;
    q.push_back(x);
  endtask

  // Memory-handshake cycle: honoured waits on dut1, ignored ready on dut2.
  task automatic push_mem(input int waits, input logic [15:0] e_wait, input logic [15:0] e_go);
    if (sel == 0) begin
      for (int i = 0; i < waits; i++) push(1'b0, e_wait);
      push(1'b1, e_go);
    end else begin
      push(rnd(), e_go);
    end
  endtask

  task automatic push_fetch(input int fw);
    push_mem(fw, ov(0,0,0,0,0,1,0,0, 0,2,0,2), ov(0,1,0,1,0,1,0,0, 0,2,0,2));
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(rnd(), ov(1,0,0,0,0,0,0,0, 0,0,0,0));
  endtask

  task automatic do_instr(input int k, input int fw, input int mw);
    logic [15:0] awb;
    awb = ov(0,0,0,0,0,0,0,1, 0,0,0,0);
    cur_opc = kop(k);
    push_fetch(fw);
    push(rnd(), ov(0,0,0,0,0,0,0,0, 1,1,0,0));
    case (k)
      0: begin
        push(rnd(), ov(0,0,0,0,0,0,0,0, 2,1,0,0));
        push_mem(mw, ov(0,0,0,0,1,1,0,0, 0,0,0,0), ov(0,0,0,0,1,1,0,0, 0,0,0,0));
        push(rnd(), ov(0,0,0,0,0,0,0,1, 0,0,0,1));
      end
      1: begin
        push(rnd(), ov(0,0,0,0,0,0,0,0, 2,1,0,0));
        push_mem(mw, ov(0,0,0,0,1,0,1,0, 0,0,0,0), ov(0,0,0,0,1,0,1,0, 0,0,0,0));
      end
      2: begin push(rnd(), ov(0,0,0,0,0,0,0,0, 2,0,2,0)); push(rnd(), awb); end
      3: begin push(rnd(), ov(0,0,0,0,0,0,0,0, 2,1,3,0)); push(rnd(), awb); end
      4: push(rnd(), ov(0,0,1,0,0,0,0,0, 2,0,1,0));
      5: begin push(rnd(), ov(0,1,0,0,0,0,0,0, 1,2,0,0)); push(rnd(), awb); end
      6: begin
        push(rnd(), ov(0,1,0,0,0,0,0,0, 2,1,0,2));
        push(rnd(), ov(0,0,0,0,0,0,0,1, 1,2,0,2));
      end
      7, 8: begin
        if (sel == 0) begin
          push(rnd(), ov(0,0,0,0,0,0,0,0, (k == 7) ? 3 : 1, 1, 0, 0));
          push(rnd(), awb);
        end else begin
          push_trap(20);
        end
      end
      default: push_trap(20);
    endcase
    if (!(k == 9 || (sel == 1 && (k == 7 || k == 8)))) cur_cnt++;
  endtask

  task automatic run_q();
    rec_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      @(posedge clk);
      #1;
      tb_opc = x.opc;
      tb_rdy = x.rdy;
      @(negedge clk);
      if (sel == 0) begin
        chk("out1", 64'(w_got1), 64'(x.exp));
        chk("instret1", 64'(if1.instret), 64'(x.cnt));
      end else begin
        chk("out2", 64'(w_got2), 64'(x.exp));
        chk("instret2", 64'(if2.instret), 64'(x.cnt % 16));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    sel = 0; rst1 = 1'b0; rst2 = 1'b0; tb_opc = '0; tb_rdy = 1'b0; cur_cnt = 0; cur_opc = '0;
    repeat (3) @(negedge clk);
    chk("rst_out1", 64'(w_got1), 64'd0);
    chk("rst_cnt1", 64'(if1.instret), 64'd0);
    chk("rst_out2", 64'(w_got2), 64'd0);
    rst1 = 1'b1;

    do_instr(2, 0, 0);
    do_instr(0, 0, 2);
    do_instr(6, 0, 0);
    run_q();
    for (int n = 0; n < 40; n++) begin
      do_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)));
      run_q();
    end

    // Async reset in the middle of a stalled store.
    cur_opc = kop(1);
    push_fetch(0);
    push(rnd(), ov(0,0,0,0,0,0,0,0, 1,1,0,0));
    push(rnd(), ov(0,0,0,0,0,0,0,0, 2,1,0,0));
    run_q();
    @(posedge clk);
    #1 tb_rdy = 1'b0;
    @(negedge clk);
    chk("mw_pre", 64'(if1.mem_write), 64'd1);
    chk("cnt_pre", 64'(if1.instret), 64'(cur_cnt));
    #2 rst1 = 1'b0;
    #1;
    chk("mw_async", 64'(if1.mem_write), 64'd0);
    chk("mr_async", 64'(if1.mem_read), 64'd0);
    chk("out_async", 64'(w_got1), 64'd0);
    chk("cnt_async", 64'(if1.instret), 64'd0);
    @(negedge clk);
    rst1 = 1'b1;
    cur_cnt = 0;
    do_instr(2, 0, 0);
    do_instr(9, 0, 0);
    run_q();

    // Second config: no wait states, no upper ops, 4-bit counter.
    rst1 = 1'b0;
    sel = 1;
    cur_cnt = 0;
    @(negedge clk);
    rst2 = 1'b1;
    for (int n = 0; n < 17; n++) do_instr(4, 0, 0);
    do_instr(7, 0, 0);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control FSM for the RISC-V core, the successor to the single-cycle main controller. Sequences each instruction through fetch, decode, execute, memory and writeback states, drives the shared-datapath selects and enables, and waits on a memory ready handshake. Adds LUI/AUIPC support, sticky illegal-opcode trapping and a retired-instruction counter. Sits between the instruction register and the multi-cycle datapath.

## Interface
- `MEM_WAIT`, 1: 1 = honour `mem_ready`; 0 = memory treated as always ready.
- `SUPPORT_UPPER`, 1: 1 = LUI (0110111) and AUIPC (0010111) legal; 0 = both trap.
- `CNT_W`, 32: width of `instret`.
- Reset is asynchronous, active-low; one clock.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  7  instruction register [6:0].
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_write`  out  1  unconditional PC update.
- `branch`  out  1  datapath updates PC if ALU zero.
- `ir_write`  out  1  latch instruction and oldPC.
- `adr_src`  out  1  0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register-file write.
- `alu_src_a`  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
- `alu_src_b`  out  2  00 rs2, 01 imm, 10 constant 4.
- `alu_op`  out  2  00 add, 01 sub, 10 R-type funct, 11 I-type funct.
- `result_src`  out  2  00 ALUOut, 01 read data, 10 ALU result.
- `trap`  out  1  illegal opcode seen; sticky.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- Moore outputs decoded from state. Outputs not listed for a state are 0.
- RST: all outputs 0. Next state is FETCH.
- FETCH: adr_src=0, mem_read=1, a=00, b=10, op=00, result_src=10; ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: a=01, b=01, op=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111/0010111 → UPPER if SUPPORT_UPPER
  - anything else → TRAP
- MEMADR: a=10, b=01, op=00. Load goes to MEMREAD; store goes to MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state is FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: a=10, b=00, op=10. Next state is ALUWB.
- EXEC_I: a=10, b=01, op=11. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state is FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00, branch=1. Next state is FETCH.
- JAL: a=01, b=10, op=00, result_src=00, pc_write=1. Next state is ALUWB (rd ← oldPC+4).
- JALR: a=10, b=01, op=00, result_src=10, pc_write=1. Next state is JALR_LINK.
- JALR_LINK: a=01, b=10, op=00, result_src=10, reg_write=1. Next state is FETCH.
- UPPER: a=11 for LUI or 01 for AUIPC, b=01, op=00. Next state is ALUWB.
- TRAP: trap=1, all enables 0. Holds until reset.
- `instret` increments by 1 on each transition into FETCH from any state other than RST. It wraps modulo 2^CNT_W.

## Timing
- Reset value: state=RST, instret=0, trap=0, every output 0.
- Reset assertion is asynchronous: mem_write and mem_read drop immediately, mid-access included.
- First FETCH is one cycle after rst_n deasserts.
- Cycle counts with zero wait states:
  - R/I/UPPER/JAL: 4
  - load: 5
  - store: 4
  - branch: 3
  - JALR: 4
- Each cycle of mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one cycle. Requests are held stable while waiting.
- With MEM_WAIT=0, mem_ready is ignored and treated as 1.
- opcode is sampled only in DECODE and MEMADR. It must stay stable from FETCH exit until the next FETCH.
- mem_ready outside a memory state is ignored.

## Structure
- Shared package `ctrl_pkg`:
  - state enum
  - opcode constants
  - alu_src_a/alu_src_b/alu_op/result_src encodings
- One sub-module, `instr_classifier` (combinational), maps opcode to class and legality given SUPPORT_UPPER.
- The FSM, output decode and counter are in the top module.

## Test plan
- Reset, then R-type (0110011) with mem_ready=1: states FETCH, DECODE, EXEC_R, ALUWB, FETCH; reg_write=1 only in cycle 4; instret=1.
- Load with mem_ready low 2 cycles in MEMREAD: mem_read and adr_src=1 held 3 cycles; MEMWB result_src=01; total 7 cycles.
- JALR: pc_write=1 with result_src=10, then reg_write=1 with a=01, b=10.
- Opcode 0110111 with SUPPORT_UPPER=0: trap=1 from the cycle after DECODE; it persists, and all enables stay 0 for 20 cycles.
- rst_n pulled low during MEMWRITE: mem_write=0 in the same cycle; instret=0; FETCH one cycle after release.
- CNT_W=4: 16 retired branches wrap instret from 15 to 0.
